t_struct_word_serializer: RTL and testbench
===========================================

// Module: t_struct_word_serializer
// PURPOSE
//  Downstream consumer of packed-struct tables of the form struct{logic [NW-1:0][DW-1:0] a}.
//  - Accepts one whole struct per valid/ready transfer.
//  - Emits the struct's words one beat per cycle on a valid/ready stream, lowest element [0] first.
//  - Tags each beat with its element index and a last flag, and counts completed structs.
//  - Used by trace regressions to walk localparam struct arrays element by element.
// PARAMETERS
//  NW  3   words per struct (>=1)
//  DW  32  bits per word (>=1)
//  IW  (NW>1 ? $clog2(NW) : 1)  index width, derived; not overridden
// PORTS
//  clk       in   1      clock, rising edge
//  rst_n     in   1      asynchronous reset, active low
//  in_valid  in   1      in_data holds a struct to load
//  in_ready  out  1      block accepts in_data this cycle
//  in_data   in   NW*DW  packed struct; element k = in_data[k*DW +: DW]
//  out_valid out  1      out_data/out_idx/out_last valid
//  out_ready in   1      sink accepts current beat
//  out_data  out  DW     current word
//  out_idx   out  IW     element index of current word
//  out_last  out  1      current word is element NW-1
//  done_cnt  out  32     count of structs fully emitted
// BEHAVIOUR
//  Reset (rst_n low, async):
//  - state=IDLE; out_valid=0, out_data=0, out_idx=0, out_last=0, done_cnt=0, shift reg=0.
//  - in_ready forced 0 while rst_n low.
//  States IDLE and SEND:
//  - IDLE: out_valid=0, in_ready=1.
//    in_valid&in_ready at edge k: latch in_data, go to SEND.
//    At k+1: out_valid=1, out_idx=0, out_data=element 0 (1-cycle latency).
//  - SEND: out_valid=1. Beat fires when out_valid&out_ready.
//    Non-last beat fires: idx+1, next element presented next cycle.
//    Beat not fired: out_data/out_idx/out_last held stable (no change under stall).
//    Last beat fires: done_cnt+1 (wraps 2^32-1 -> 0), then:
//      in_valid=1 -> new struct loaded same edge; next cycle out_idx=0, out_valid stays 1 (no bubble).
//      otherwise -> IDLE.
//  - in_ready = (state==IDLE) | (out_valid & out_ready & out_last); combinational from out_ready.
//    in_ready=0 in all other SEND cycles; in_data ignored then.
//  - out_last = (out_idx==NW-1). NW=1: every beat is last; struct streams at 1 beat/cycle.
//  - out_valid never drops in SEND until last beat fires.
//    out_ready ignored when out_valid=0.
//  - Reset mid-struct: remaining words discarded, done_cnt=0, no partial beat after release.
//  - Throughput: NW beats per struct, back-to-back structs gap-free under continuous out_ready.
// TESTING
//  1 Reset: assert rst_n=0 mid-cycle -> all outputs 0 immediately (async), in_ready=0.
//    Release -> in_ready=1, out_valid=0.
//  2 Single struct {32'h10000002,32'h10000001,32'h10000000}, out_ready=1:
//    beats 10000000/idx0, 10000001/idx1, 10000002/idx2/last, cycles k+1..k+3.
//    done_cnt=1, then IDLE.
//  3 Backpressure: out_ready=0 for 4 cycles at idx1 -> out_data held 10000001, idx1, valid=1.
//    Resume -> idx2 next beat.
//  4 Back-to-back: three structs 1x,2x,3x queued, in_valid=1, out_ready=1 -> 9 consecutive valid beats,
//    no bubble, in_ready pulses only on last beats, done_cnt=3.
//  5 Mid-op reset: rst_n=0 after idx1 beat -> out_valid=0, done_cnt=0.
//    Next load restarts at idx0.
//  6 NW=1, DW=8: load 8'hA5 then 8'h5A back-to-back -> two beats, both last, idx0, done_cnt=2.

Source files
------------

// File: rtl/t_struct_word_serializer.sv
// Struct-to-word serializer: accepts one packed struct of NW words per handshake
// and streams its elements lowest-first, tagging each beat with index and last.
module t_struct_word_serializer #(
    parameter int NW = 3,
    parameter int DW = 32,
    localparam int IW = (NW > 1) ? $clog2(NW) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [NW*DW-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  out_data,
    output logic [IW-1:0]  out_idx,
    output logic           out_last,
    output logic [31:0]    done_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam logic [IW-1:0] LastIdx = IW'(NW - 1);

    state_e             state_q, state_d;
    logic [NW*DW-1:0]   shift_q, shift_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [31:0]        done_q, done_d;

    logic               beatFire;
    logic               beatLast;

    assign out_valid = (state_q == SEND);
    assign beatLast  = (idx_q == LastIdx);
    assign beatFire  = out_valid & out_ready;
    assign out_data  = shift_q[DW-1:0];
    assign out_idx   = idx_q;
    assign out_last  = out_valid & beatLast;
    assign done_cnt  = done_q;

    // Ready in IDLE, or on the cycle the last beat leaves, so a queued struct follows with no bubble.
    assign in_ready  = rst_n & ((state_q == IDLE) | (beatFire & beatLast));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        done_d  = done_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    shift_d = in_data;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (beatFire) begin
                    if (beatLast) begin
                        done_d = done_q + 32'd1;
                        idx_d  = '0;
                        if (in_valid) begin
                            shift_d = in_data;
                            state_d = SEND;
                        end else begin
                            shift_d = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        // Element 0 always sits in the low word, so advancing is a right shift.
                        shift_d = shift_q >> DW;
                        idx_d   = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_t_struct_word_serializer.sv
// Scoreboard bench for t_struct_word_serializer: a 3x32 instance for the main
// scenarios and a 1x8 instance for the single-word corner case.
module tb_t_struct_word_serializer;

    typedef struct {
        logic [31:0] data;
        int          idx;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst_n;

    logic        inValid1, inReady1, outValid1, outReady1, outLast1;
    logic [95:0] inData1;
    logic [31:0] outData1, doneCnt1;
    logic [1:0]  outIdx1;

    logic        inValid2, inReady2, outValid2, outReady2, outLast2;
    logic [7:0]  inData2, outData2;
    logic [31:0] doneCnt2;
    logic [0:0]  outIdx2;

    beat_t sb1[$];
    beat_t sb2[$];

    int checkCount = 0;
    int errorCount = 0;
    int irPulses;

    t_struct_word_serializer #(.NW(3), .DW(32)) dutWide (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValid1), .in_ready(inReady1), .in_data(inData1),
        .out_valid(outValid1), .out_ready(outReady1), .out_data(outData1),
        .out_idx(outIdx1), .out_last(outLast1), .done_cnt(doneCnt1)
    );

    t_struct_word_serializer #(.NW(1), .DW(8)) dutNarrow (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValid2), .in_ready(inReady2), .in_data(inData2),
        .out_valid(outValid2), .out_ready(outReady2), .out_data(outData2),
        .out_idx(outIdx2), .out_last(outLast2), .done_cnt(doneCnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every comparison and report mismatches on one line.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Beats are sampled on the falling edge; a beat counts when valid and ready are both high.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n && outValid1 && outReady1) begin
            if (sb1.size() == 0) begin
                checkOutput("wideUnexpectedBeat", 64'(outData1), 64'hDEAD);
            end else begin
                e = sb1.pop_front();
                checkOutput("wideData", 64'(outData1), 64'(e.data));
                checkOutput("wideIdx",  64'(outIdx1),  64'(e.idx));
                checkOutput("wideLast", 64'(outLast1), 64'(e.last));
            end
        end
        if (rst_n && outValid2 && outReady2) begin
            if (sb2.size() == 0) begin
                checkOutput("narrowUnexpectedBeat", 64'(outData2), 64'hDEAD);
            end else begin
                e = sb2.pop_front();
                checkOutput("narrowData", 64'(outData2), 64'(e.data));
                checkOutput("narrowIdx",  64'(outIdx2),  64'(e.idx));
                checkOutput("narrowLast", 64'(outLast2), 64'(e.last));
            end
        end
    end

    task automatic applyStimulus(input logic [95:0] data);
        bit accepted = 0;
        beat_t e;
        inValid1 = 1'b1;
        inData1  = data;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (inReady1) begin
                accepted = 1;
                break;
            end
        end
        if (!accepted) begin
            checkOutput("wideLoadTimeout", 64'd0, 64'd1);
        end else begin
            for (int k = 0; k < 3; k++) begin
                e.data = data[k*32 +: 32];
                e.idx  = k;
                e.last = (k == 2);
                sb1.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        inValid1 = 1'b0;
    endtask

    task automatic applyNarrow(input logic [7:0] data);
        bit accepted = 0;
        beat_t e;
        inValid2 = 1'b1;
        inData2  = data;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (inReady2) begin
                accepted = 1;
                break;
            end
        end
        if (!accepted) begin
            checkOutput("narrowLoadTimeout", 64'd0, 64'd1);
        end else begin
            e.data = 32'(data);
            e.idx  = 0;
            e.last = 1'b1;
            sb2.push_back(e);
        end
        @(posedge clk);
        #1;
        inValid2 = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        bit idle = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (sb1.size() == 0 && !outValid1 && sb2.size() == 0 && !outValid2) begin
                idle = 1;
                break;
            end
        end
        checkOutput(tag, 64'(idle), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        inValid1 = 1'b0; inData1 = '0; outReady1 = 1'b1;
        inValid2 = 1'b0; inData2 = '0; outReady2 = 1'b1;
        #2;
        checkOutput("resetInReady",  64'(inReady1),  64'd0);
        checkOutput("resetOutValid", 64'(outValid1), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("releaseInReady",  64'(inReady1),  64'd1);
        checkOutput("releaseOutValid", 64'(outValid1), 64'd0);
        checkOutput("releaseDone",     64'(doneCnt1),  64'd0);

        // Asynchronous reset asserted mid-cycle
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncInReady",  64'(inReady1),  64'd0);
        checkOutput("asyncOutValid", 64'(outValid1), 64'd0);
        checkOutput("asyncOutData",  64'(outData1),  64'd0);
        checkOutput("asyncOutIdx",   64'(outIdx1),   64'd0);
        checkOutput("asyncOutLast",  64'(outLast1),  64'd0);
        checkOutput("asyncDone",     64'(doneCnt1),  64'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("asyncReleaseReady", 64'(inReady1), 64'd1);

        // Single struct, continuous ready
        applyStimulus({32'h10000002, 32'h10000001, 32'h10000000});
        checkOutput("firstBeatValid", 64'(outValid1), 64'd1);
        checkOutput("firstBeatIdx",   64'(outIdx1),   64'd0);
        waitIdle("singleDrain");
        checkOutput("singleDone", 64'(doneCnt1), 64'd1);
        checkOutput("singleIdleReady", 64'(inReady1), 64'd1);

        // Backpressure at idx1 for four cycles
        applyStimulus({32'h10000002, 32'h10000001, 32'h10000000});
        @(posedge clk);
        #1;
        checkOutput("stallStartIdx", 64'(outIdx1), 64'd1);
        outReady1 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            checkOutput("stallData",  64'(outData1),  64'h10000001);
            checkOutput("stallIdx",   64'(outIdx1),   64'd1);
            checkOutput("stallValid", 64'(outValid1), 64'd1);
            checkOutput("stallReady", 64'(inReady1),  64'd0);
        end
        outReady1 = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("resumeIdx", 64'(outIdx1), 64'd2);
        waitIdle("stallDrain");
        checkOutput("stallDone", 64'(doneCnt1), 64'd2);

        // Three structs back-to-back, no bubbles allowed
        irPulses = 0;
        fork
            begin
                applyStimulus({32'h10000012, 32'h10000011, 32'h10000010});
                applyStimulus({32'h20000022, 32'h20000021, 32'h20000020});
                applyStimulus({32'h30000032, 32'h30000031, 32'h30000030});
            end
            begin
                bit seen = 0;
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (outValid1) begin
                        seen = 1;
                        break;
                    end
                end
                checkOutput("b2bStart", 64'(seen), 64'd1);
                for (int i = 0; i < 9; i++) begin
                    checkOutput("b2bValid", 64'(outValid1), 64'd1);
                    checkOutput("b2bReadyPulse", 64'(inReady1), 64'(i % 3 == 2));
                    if (inReady1) irPulses++;
                    @(negedge clk);
                end
            end
        join
        waitIdle("b2bDrain");
        checkOutput("b2bPulses", 64'(irPulses), 64'd3);
        checkOutput("b2bDone", 64'(doneCnt1), 64'd5);

        // Reset in the middle of a struct
        applyStimulus({32'h40000002, 32'h40000001, 32'h40000000});
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("preResetIdx", 64'(outIdx1), 64'd2);
        rst_n = 1'b0;
        #1;
        checkOutput("midResetValid", 64'(outValid1), 64'd0);
        checkOutput("midResetDone",  64'(doneCnt1),  64'd0);
        checkOutput("midResetReady", 64'(inReady1),  64'd0);
        sb1.delete();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("noPartialBeat", 64'(outValid1), 64'd0);
        applyStimulus({32'h50000002, 32'h50000001, 32'h50000000});
        checkOutput("restartIdx", 64'(outIdx1), 64'd0);
        waitIdle("restartDrain");
        checkOutput("restartDone", 64'(doneCnt1), 64'd1);

        // Single-word structs stream one beat per cycle
        applyNarrow(8'hA5);
        applyNarrow(8'h5A);
        waitIdle("narrowDrain");
        checkOutput("narrowDone", 64'(doneCnt2), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
